// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared constants and types for the vector register file writeback path
package vrf_pkg;

   localparam int S_DEF     = 2;
   localparam int D_DEF     = 8;
   localparam int V_DEF     = 4;
   localparam int NUM_VREGS = 2 ** S_DEF;

   typedef logic [V_DEF-1:0][D_DEF-1:0] vec_t;
   typedef logic [S_DEF-1:0]            vaddr_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting after the last winner
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic          enable_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] cand;
   logic          found;

   // Scan requesters from ptr+1 upward, wrapping; the first valid one wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr_i) + k) % N);
         if (!found && enable_i && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// rtl/vrf_wb_arbiter.sv - shares the register file write port between writeback units and tracks busy registers
module vrf_wb_arbiter
   import vrf_pkg::*;
#(
   parameter int S = S_DEF,
   parameter int D = D_DEF,
   parameter int V = V_DEF,
   parameter int N = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N-1:0]                req_valid,
   output logic [N-1:0]                req_ready,
   input  logic [N-1:0][S-1:0]         req_addr,
   input  logic [N-1:0][V-1:0][D-1:0]  req_data,
   input  logic                        wb_stall,
   input  logic                        issue_valid,
   input  logic [S-1:0]                issue_addr,
   output logic                        issue_hazard,
   output logic [2**S-1:0]             busy,
   output logic                        we3,
   output logic [S-1:0]                wa3,
   output logic [V-1:0][D-1:0]         wd3
);

   localparam int NREG = 2 ** S;
   localparam int IW   = $clog2(N);

   logic [IW-1:0]        ptr_q;
   logic [N-1:0]         grant;
   logic [IW-1:0]        gidx;
   logic                 xfer;
   logic                 arb_en;
   logic [S-1:0]         win_addr;
   logic [V-1:0][D-1:0]  win_data;
   logic                 issue_set;
   logic [NREG-1:0]      busy_q, busy_d;
   logic                 we3_q;
   logic [S-1:0]         wa3_q;
   logic [V-1:0][D-1:0]  wd3_q;

   // Reset also blocks grants so no requester sees ready while the block is held.
   assign arb_en = !wb_stall && !rst;

   rr_arbiter #(.N(N), .IW(IW)) u_rr (
      .req_i    (req_valid),
      .enable_i (arb_en),
      .ptr_i    (ptr_q),
      .grant_o  (grant),
      .idx_o    (gidx),
      .any_o    (xfer)
   );

   assign req_ready = grant;
   assign win_addr  = req_addr[gidx];
   assign win_data  = req_data[gidx];

   assign issue_hazard = issue_valid & busy_q[issue_addr];
   assign issue_set    = issue_valid & !busy_q[issue_addr] & (issue_addr != '0);

   // Scoreboard next state: clear on writeback, then set, so a new reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (xfer && (win_addr != '0)) begin
         busy_d[win_addr] = 1'b0;
      end
      if (issue_set) begin
         busy_d[issue_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Remember the last winner so the next scan starts just after it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (xfer) begin
         ptr_q <= gidx;
      end
   end

   // Registered write port; register 0 is accepted but never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we3_q <= 1'b0;
         wa3_q <= '0;
         wd3_q <= '0;
      end else if (xfer) begin
         we3_q <= (win_addr != '0);
         wa3_q <= win_addr;
         wd3_q <= win_data;
      end else begin
         we3_q <= 1'b0;
      end
   end

   // Busy scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;
   assign we3  = we3_q;
   assign wa3  = wa3_q;
   assign wd3  = wd3_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb/tb_vrf_wb_arbiter.sv - self-checking bench for vrf_wb_arbiter
module tb_vrf_wb_arbiter;

   localparam int S  = 2;
   localparam int D  = 8;
   localparam int V  = 4;
   localparam int N  = 2;
   localparam int NR = 4;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [N-1:0]               req_valid;
   logic [N-1:0]               req_ready;
   logic [N-1:0][S-1:0]        req_addr;
   logic [N-1:0][V-1:0][D-1:0] req_data;
   logic                       wb_stall;
   logic                       issue_valid;
   logic [S-1:0]               issue_addr;
   logic                       issue_hazard;
   logic [NR-1:0]              busy;
   logic                       we3;
   logic [S-1:0]               wa3;
   logic [V-1:0][D-1:0]        wd3;

   int checks = 0;
   int errors = 0;

   vrf_wb_arbiter #(.S(S), .D(D), .V(V), .N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .wb_stall     (wb_stall),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .issue_hazard (issue_hazard),
      .busy         (busy),
      .we3          (we3),
      .wa3          (wa3),
      .wd3          (wd3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: last winner, reserved registers, pending write.
   int             m_last = 0;
   logic [NR-1:0]  m_busy = '0;
   logic           m_we   = 1'b0;
   logic [S-1:0]   m_wa   = '0;
   logic [31:0]    m_wd   = '0;
   logic [NR-1:0][31:0] rf = '0;

   function automatic int pick();
      if (rst || wb_stall) return -1;
      for (int k = 1; k <= N; k++) begin
         int c = (m_last + k) % N;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_last = 0;
         m_busy = '0;
         m_we   = 1'b0;
         m_wa   = '0;
         m_wd   = '0;
      end else begin
         int   w;
         logic hz;
         w  = pick();
         hz = issue_valid && m_busy[issue_addr];
         if (w >= 0) begin
            m_last = w;
            m_we   = (req_addr[w] != 0);
            m_wa   = req_addr[w];
            m_wd   = req_data[w];
            if (req_addr[w] != 0) m_busy[req_addr[w]] = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (issue_valid && !hz && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
   end

   // Register file sink: writes land on the negedge after we3 rises.
   always @(negedge clk) begin
      if (we3) rf[wa3] <= wd3;
   end

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      int          w;
      logic [N-1:0] er;
      w  = pick();
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("ready",  req_ready,    er);
      chk("hazard", issue_hazard, issue_valid && m_busy[issue_addr]);
      chk("we3",    we3,          m_we);
      chk("wa3",    wa3,          m_wa);
      chk("wd3",    wd3,          m_wd);
      chk("busy",   busy,         m_busy);
   end

   task automatic drive_wait();
      @(posedge clk);
      #2;
   endtask

   logic [N-1:0] g [4];

   initial begin
      rst = 1'b1;
      req_valid = 2'b11;
      req_addr = '0;
      req_data = '0;
      wb_stall = 1'b0;
      issue_valid = 1'b0;
      issue_addr = '0;
      repeat (2) drive_wait();
      #1;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_we3",   we3,       1'b0);
      chk("rst_busy",  busy,      4'b0000);
      rst = 1'b0;
      req_valid = 2'b00;
      drive_wait();

      // Single requester
      req_valid = 2'b01;
      req_addr[0] = 2'd2;
      req_data[0] = 32'h11223344;
      #1 chk("single_ready", req_ready, 2'b01);
      drive_wait();
      req_valid = 2'b00;
      #1;
      chk("single_we3", we3, 1'b1);
      chk("single_wa3", wa3, 2'd2);
      chk("single_wd3", wd3, 32'h11223344);
      drive_wait();
      chk("single_rf", rf[2], 32'h11223344);
      chk("single_we3_off", we3, 1'b0);

      // Reset mid-write
      req_valid = 2'b01;
      req_addr[0] = 2'd1;
      req_data[0] = 32'haabbccdd;
      issue_valid = 1'b1;
      issue_addr = 2'd3;
      drive_wait();
      req_valid = 2'b00;
      issue_valid = 1'b0;
      #1;
      chk("pre_rst_we3",  we3,  1'b1);
      chk("pre_rst_busy", busy, 4'b1000);
      rst = 1'b1;
      #1;
      chk("mid_rst_we3",  we3,  1'b0);
      chk("mid_rst_wa3",  wa3,  2'd0);
      chk("mid_rst_wd3",  wd3,  32'h0);
      chk("mid_rst_busy", busy, 4'b0000);
      drive_wait();
      rst = 1'b0;
      drive_wait();

      // Contention from pointer 0
      req_valid = 2'b11;
      req_addr[0] = 2'd1;
      req_addr[1] = 2'd3;
      req_data[0] = 32'h01020304;
      req_data[1] = 32'h0a0b0c0d;
      for (int i = 0; i < 4; i++) begin
         #1 g[i] = req_ready;
         drive_wait();
         chk("cont_we3", we3, 1'b1);
      end
      req_valid = 2'b00;
      chk("cont_g0", g[0], 2'b10);
      chk("cont_g1", g[1], 2'b01);
      chk("cont_g2", g[2], 2'b10);
      chk("cont_g3", g[3], 2'b01);
      drive_wait();
      chk("cont_we3_off", we3, 1'b0);
      chk("cont_rf1", rf[1], 32'h01020304);
      chk("cont_rf3", rf[3], 32'h0a0b0c0d);

      // Scoreboard
      issue_valid = 1'b1;
      issue_addr = 2'd3;
      #1 chk("sb_hz0", issue_hazard, 1'b0);
      drive_wait();
      #1;
      chk("sb_set", busy, 4'b1000);
      chk("sb_hz1", issue_hazard, 1'b1);
      drive_wait();
      chk("sb_hold", busy, 4'b1000);
      issue_valid = 1'b0;
      req_valid = 2'b01;
      req_addr[0] = 2'd3;
      drive_wait();
      req_valid = 2'b00;
      #1 chk("sb_clear", busy, 4'b0000);
      issue_valid = 1'b1;
      req_valid = 2'b01;
      drive_wait();
      issue_valid = 1'b0;
      req_valid = 2'b00;
      #1 chk("sb_setwins", busy, 4'b1000);
      req_valid = 2'b01;
      drive_wait();
      req_valid = 2'b00;
      #1 chk("sb_clear2", busy, 4'b0000);

      // Register 0
      req_valid = 2'b01;
      req_addr[0] = 2'd0;
      issue_valid = 1'b1;
      issue_addr = 2'd0;
      #1 chk("r0_ready", req_ready, 2'b01);
      drive_wait();
      req_valid = 2'b00;
      issue_valid = 1'b0;
      #1;
      chk("r0_we3",  we3,  1'b0);
      chk("r0_busy", busy, 4'b0000);

      // Stall
      wb_stall = 1'b1;
      req_valid = 2'b01;
      req_addr[0] = 2'd1;
      req_data[0] = 32'h55667788;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_ready", req_ready, 2'b00);
         drive_wait();
         chk("stall_we3", we3, 1'b0);
      end
      wb_stall = 1'b0;
      #1 chk("unstall_ready", req_ready, 2'b01);
      drive_wait();
      req_valid = 2'b00;
      #1;
      chk("unstall_we3", we3, 1'b1);
      chk("unstall_wa3", wa3, 2'd1);
      chk("unstall_wd3", wd3, 32'h55667788);

      repeat (2) drive_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vrf_wb_arbiter.md
Name: vrf_wb_arbiter

Overview:
- Shares the single write port of the vector register file (we3/wa3/wd3) between N writeback requesters, e.g. vector ALU and vector load unit.
- Uses round-robin arbitration and a registered output stage.
- Keeps a per-register busy scoreboard: set at issue, cleared at writeback. The decode stage uses it for write-after-write and read-after-write hazard checks.
- Sits between the execution units and the register file.

Parameters:
- S, 2, register address width; 2**S vector registers.
- D, 8, element width in bits.
- V, 4, lanes per vector.
- N, 2, number of writeback requesters (2..4).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  requester i has a writeback pending.
- req_ready  out  N  requester i granted this cycle; transfer when valid&ready.
- req_addr  in  N x S  destination register per requester.
- req_data  in  N x V x D  vector data per requester.
- wb_stall  in  1  freeze writeback (register file port borrowed elsewhere).
- issue_valid  in  1  decode reserves a destination register.
- issue_addr  in  S  register being reserved.
- issue_hazard  out  1  combinational: issue_valid & busy[issue_addr].
- busy  out  2**S  scoreboard vector; bit 0 always 0.
- we3  out  1  register file write enable (registered).
- wa3  out  S  register file write address (registered).
- wd3  out  V x D  register file write data (registered).

Behaviour:
- Reset (async, immediate): we3=0, wa3=0, wd3 all lanes 0, busy=0, rr pointer=0, req_ready=0.
- Arbitration is combinational each cycle.
  - Candidates are requesters with req_valid=1; wb_stall=1 forces req_ready=0.
  - Priority order starts at requester (ptr+1) mod N, wrapping.
  - At most one req_ready bit is high (one-hot or zero).
- Pointer update: on a transfer, ptr <= granted index; with no transfer, ptr holds.
- Output stage:
  - On posedge after a transfer: we3<=1 (0 if req_addr==0), wa3<=req_addr, wd3<=req_data of the winner.
  - With no transfer: we3<=0; wa3/wd3 hold their last values.
- Latency: grant cycle to we3 high is 1 clock. The register file writes on the following negedge, so data is readable the next cycle.
- Throughput: one writeback per cycle; back-to-back grants allowed.
- Writes to register 0 are accepted (ready asserted) but produce no we3 pulse.
- Scoreboard, on posedge:
  - Set: issue_valid & !issue_hazard & issue_addr!=0 sets busy[issue_addr].
  - Clear: a transfer with req_addr!=0 clears busy[req_addr] at the same posedge that loads the output stage.
  - Set and clear of the same register in the same cycle: set wins (new reservation).
  - Clear of an already non-busy register: no effect, no error.
- issue_hazard: issue_valid=1 to a busy register raises issue_hazard and does not set busy. Decode must stall.
- wb_stall mid-stream: the output stage drains (we3=0 next cycle); requesters hold valid/addr/data until granted.
- req_valid must not drop before ready (requester rule; not checked).
- Reset asserted mid-operation: the in-flight output-stage write is discarded (we3 drops immediately) and all reservations are lost.

Decomposition:
- Package vrf_pkg holds:
  - S/D/V default constants.
  - typedef vec_t (V x D packed-lane array).
  - typedef vaddr_t (S bits).
  - NUM_VREGS = 2**S.
- Sub-module rr_arbiter #(N) contains the round-robin grant logic: inputs req, enable, ptr; outputs one-hot grant and index. The pointer register stays in the parent.

Test Plan:
- Reset mid-write: assert rst while we3=1 -> we3, wa3, wd3, busy go to 0 immediately.
- Single requester: req0 addr=2 data={8'h11,8'h22,8'h33,8'h44}.
  - Expected: ready0=1 same cycle; next cycle we3=1, wa3=2, wd3 matches.
  - Expected: the register file reads the value back the cycle after.
- Contention: both valid for 4 cycles, addrs 1 and 3, ptr=0 at reset.
  - Expected grants: req1, req0, req1, req0.
  - Expected we3 stays high 4 consecutive cycles.
- Scoreboard:
  - issue addr=3 -> busy=4'b1000.
  - Re-issue addr=3 -> issue_hazard=1, busy unchanged.
  - Writeback to 3 -> busy=0.
  - Same-cycle issue 3 plus writeback 3 -> busy[3] stays 1.
- Register 0: req addr=0 -> ready=1, we3 stays 0, busy[0] stays 0.
- Stall: wb_stall=1 for 3 cycles with req0 valid -> ready0=0 and we3=0 throughout; grant occurs the cycle wb_stall drops.
